// File: rtl/projectile_pool.sv
`default_nettype none
// ============================================================================
//  Module      : projectile_pool
//  Description : Multi-slot venom projectile engine. Launches shots from the
//                snake head in one of four cardinal directions, advances every
//                live shot SPEED pixels per frame, retires shots on screen-edge
//                exit or an external hit report, and rate-limits launches
//                with a frame cooldown.
//  Revision    : 1.0 - initial release
// ============================================================================
module projectile_pool #(
  parameter int NUM_SLOTS = 4,
  parameter int SPEED     = 3,
  parameter int SIZE      = 4,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int COOLDOWN  = 8,
  localparam int SW       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    fire_req,
  input  logic [1:0]              fire_dir,
  input  logic [9:0]              origin_x,
  input  logic [9:0]              origin_y,
  input  logic                    hit_valid,
  input  logic [SW-1:0]           hit_slot,
  output logic [NUM_SLOTS-1:0]    active,
  output logic [NUM_SLOTS*10-1:0] pos_x,
  output logic [NUM_SLOTS*10-1:0] pos_y,
  output logic [9:0]              size,
  output logic                    fire_ack,
  output logic                    fire_drop
);

  // Cooldown counter only needs to hold values 0..COOLDOWN.
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [10:0]   SPEED_EXT    = 11'(SPEED);
  localparam logic [10:0]   X_MAX_EXT    = 11'(X_MAX);
  localparam logic [10:0]   Y_MAX_EXT    = 11'(Y_MAX);
  localparam logic [CW-1:0] COOLDOWN_VAL = CW'(COOLDOWN);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [9:0]           x_q   [NUM_SLOTS];
  logic [9:0]           x_d   [NUM_SLOTS];
  logic [9:0]           y_q   [NUM_SLOTS];
  logic [9:0]           y_d   [NUM_SLOTS];
  logic [1:0]           dir_q [NUM_SLOTS];
  logic [1:0]           dir_d [NUM_SLOTS];
  logic [CW-1:0]        cooldown_q, cooldown_d;
  logic                 fire_ack_q, fire_ack_d;
  logic                 fire_drop_q, fire_drop_d;

  logic                 any_free;
  logic [SW-1:0]        free_idx;
  logic                 accept;

  // Pick the lowest-index slot that was idle before this edge and decide
  // whether a launch request can be honoured.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        any_free = 1'b1;
        free_idx = SW'(i);
      end
    end
    accept = fire_req && (cooldown_q == '0) && any_free;
  end

  // Next-state for every slot (hit, movement, launch) plus cooldown and pulses.
  always_comb begin
    logic [10:0] ext_x;
    logic [10:0] ext_y;
    logic [10:0] sum;
    logic        slot_hit;
    ext_x    = '0;
    ext_y    = '0;
    sum      = '0;
    slot_hit = 1'b0;
    active_d = active_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      x_d[i]   = x_q[i];
      y_d[i]   = y_q[i];
      dir_d[i] = dir_q[i];
      ext_x    = {1'b0, x_q[i]};
      ext_y    = {1'b0, y_q[i]};
      slot_hit = hit_valid && (int'(hit_slot) == i) && (int'(hit_slot) < NUM_SLOTS);
      if (active_q[i]) begin
        // A hit wins over movement; a hit plus edge exit is one retirement.
        if (slot_hit) begin
          active_d[i] = 1'b0;
        end else begin
          case (dir_q[i])
            DIR_UP: begin
              sum = ext_y - SPEED_EXT;
              if (ext_y < SPEED_EXT) active_d[i] = 1'b0;
              else                   y_d[i]      = sum[9:0];
            end
            DIR_LEFT: begin
              sum = ext_x - SPEED_EXT;
              if (ext_x < SPEED_EXT) active_d[i] = 1'b0;
              else                   x_d[i]      = sum[9:0];
            end
            DIR_DOWN: begin
              sum = ext_y + SPEED_EXT;
              if (sum > Y_MAX_EXT) active_d[i] = 1'b0;
              else                 y_d[i]      = sum[9:0];
            end
            default: begin
              sum = ext_x + SPEED_EXT;
              if (sum > X_MAX_EXT) active_d[i] = 1'b0;
              else                 x_d[i]      = sum[9:0];
            end
          endcase
        end
      end else if (accept && (free_idx == SW'(i))) begin
        // Launch edge: load origin, no movement until the next frame.
        active_d[i] = 1'b1;
        x_d[i]      = origin_x;
        y_d[i]      = origin_y;
        dir_d[i]    = fire_dir;
      end
    end

    if (accept)                 cooldown_d = COOLDOWN_VAL;
    else if (cooldown_q != '0)  cooldown_d = cooldown_q - 1'b1;
    else                        cooldown_d = cooldown_q;

    fire_ack_d  = accept;
    fire_drop_d = fire_req && !accept;
  end

  // State registers; reset kills every projectile immediately.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      active_q    <= '0;
      cooldown_q  <= '0;
      fire_ack_q  <= 1'b0;
      fire_drop_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]   <= '0;
        y_q[i]   <= '0;
        dir_q[i] <= DIR_UP;
      end
    end else begin
      active_q    <= active_d;
      cooldown_q  <= cooldown_d;
      fire_ack_q  <= fire_ack_d;
      fire_drop_q <= fire_drop_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
        dir_q[i] <= dir_d[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
      assign pos_x[10*g +: 10] = x_q[g];
      assign pos_y[10*g +: 10] = y_q[g];
    end
  endgenerate

  assign active    = active_q;
  assign size      = 10'(SIZE);
  assign fire_ack  = fire_ack_q;
  assign fire_drop = fire_drop_q;

  // Direction code DIR_RIGHT is the default case arm above.
  logic unused_dir;
  assign unused_dir = ^DIR_RIGHT;

endmodule
`default_nettype wire

// File: tb/tb_projectile_pool.sv
`default_nettype none
// ============================================================================
//  Module      : tb_projectile_pool
//  Description : Directed self-checking bench for projectile_pool. One
//                instance uses the default cooldown of 8, a second uses a
//                cooldown of 0; both share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_projectile_pool;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic        fire_req  = 1'b0;
  logic [1:0]  fire_dir  = 2'b00;
  logic [9:0]  origin_x  = '0;
  logic [9:0]  origin_y  = '0;
  logic        hit_valid = 1'b0;
  logic [1:0]  hit_slot  = '0;

  logic [3:0]  active8, active0;
  logic [39:0] pos_x8, pos_y8, pos_x0, pos_y0;
  logic [9:0]  size8, size0;
  logic        ack8, drop8, ack0, drop0;

  int total = 0;
  int bad   = 0;

  always #5 frame_clk = ~frame_clk;

  projectile_pool #(.COOLDOWN(8)) dut8 (
    .frame_clk(frame_clk), .Reset(Reset), .fire_req(fire_req), .fire_dir(fire_dir),
    .origin_x(origin_x), .origin_y(origin_y), .hit_valid(hit_valid), .hit_slot(hit_slot),
    .active(active8), .pos_x(pos_x8), .pos_y(pos_y8), .size(size8),
    .fire_ack(ack8), .fire_drop(drop8)
  );

  projectile_pool #(.COOLDOWN(0)) dut0 (
    .frame_clk(frame_clk), .Reset(Reset), .fire_req(fire_req), .fire_dir(fire_dir),
    .origin_x(origin_x), .origin_y(origin_y), .hit_valid(hit_valid), .hit_slot(hit_slot),
    .active(active0), .pos_x(pos_x0), .pos_y(pos_y0), .size(size0),
    .fire_ack(ack0), .fire_drop(drop0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one frame and sample just after the edge.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    Reset = 1'b1;
    #1;
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  function automatic logic [9:0] slot(input logic [39:0] v, input int i);
    return v[10*i +: 10];
  endfunction

  initial begin
    #12;
    Reset = 1'b0;

    // Reset state
    check("rst_active", 64'(active8), 64'd0);
    check("rst_posx", 64'(pos_x8), 64'd0);
    check("rst_ack_drop", 64'({ack8, drop8}), 64'd0);
    check("size", 64'(size8), 64'd4);

    // Hit on an idle slot does nothing
    hit_valid = 1'b1; hit_slot = 2'd1;
    step();
    hit_valid = 1'b0;
    check("hit_idle_active", 64'(active8), 64'd0);

    // Launch upward from (100,200) and move
    fire_req = 1'b1; fire_dir = 2'b00; origin_x = 10'd100; origin_y = 10'd200;
    step();
    fire_req = 1'b0;
    check("up_e1_active", 64'(active8), 64'b0001);
    check("up_e1_x", 64'(slot(pos_x8, 0)), 64'd100);
    check("up_e1_y", 64'(slot(pos_y8, 0)), 64'd200);
    check("up_e1_ack", 64'(ack8), 64'd1);
    step();
    check("up_e2_y", 64'(slot(pos_y8, 0)), 64'd197);
    check("up_e2_ack", 64'(ack8), 64'd0);
    step();
    check("up_e3_y", 64'(slot(pos_y8, 0)), 64'd194);
    check("up_e3_x", 64'(slot(pos_x8, 0)), 64'd100);

    // Left boundary retirement from (5,50)
    do_reset();
    fire_req = 1'b1; fire_dir = 2'b01; origin_x = 10'd5; origin_y = 10'd50;
    step();
    fire_req = 1'b0;
    check("left_e1_x", 64'(slot(pos_x8, 0)), 64'd5);
    step();
    check("left_e2_x", 64'(slot(pos_x8, 0)), 64'd2);
    check("left_e2_active", 64'(active8), 64'b0001);
    step();
    check("left_e3_active", 64'(active8), 64'b0000);
    check("left_e3_x", 64'(slot(pos_x8, 0)), 64'd2);

    // Pool exhaustion on the zero-cooldown instance
    do_reset();
    fire_req = 1'b1; fire_dir = 2'b11; origin_x = 10'd10; origin_y = 10'd10;
    step();
    check("fill_e1", 64'({active0, ack0, drop0}), 64'b0001_1_0);
    step();
    check("fill_e2", 64'({active0, ack0, drop0}), 64'b0011_1_0);
    step();
    check("fill_e3", 64'({active0, ack0, drop0}), 64'b0111_1_0);
    step();
    check("fill_e4", 64'({active0, ack0, drop0}), 64'b1111_1_0);
    check("fill_e4_x0", 64'(slot(pos_x0, 0)), 64'd19);
    check("fill_e4_x3", 64'(slot(pos_x0, 3)), 64'd10);
    step();
    check("full_e5", 64'({active0, ack0, drop0}), 64'b1111_0_1);
    check("full_e5_x0", 64'(slot(pos_x0, 0)), 64'd22);

    // Hit slot 2 together with a fire: freed slot not reusable this edge
    hit_valid = 1'b1; hit_slot = 2'd2;
    step();
    hit_valid = 1'b0;
    check("hitfire_e1", 64'({active0, ack0, drop0}), 64'b1011_0_1);
    check("hitfire_e1_x2", 64'(slot(pos_x0, 2)), 64'd16);
    fire_dir = 2'b00; origin_x = 10'd300; origin_y = 10'd301;
    step();
    check("hitfire_e2", 64'({active0, ack0, drop0}), 64'b1111_1_0);
    check("hitfire_e2_x2", 64'(slot(pos_x0, 2)), 64'd300);
    check("hitfire_e2_y2", 64'(slot(pos_y0, 2)), 64'd301);
    check("hitfire_e2_x0", 64'(slot(pos_x0, 0)), 64'd28);

    // Cooldown of 8 with fire held: launches at edges 1, 10, 19
    do_reset();
    fire_req = 1'b1; fire_dir = 2'b11; origin_x = 10'd10; origin_y = 10'd10;
    for (int e = 1; e <= 19; e++) begin
      step();
      if (e == 1 || e == 10 || e == 19) begin
        check($sformatf("cd_e%0d_ack", e), 64'(ack8), 64'd1);
        check($sformatf("cd_e%0d_drop", e), 64'(drop8), 64'd0);
      end else begin
        check($sformatf("cd_e%0d_ack", e), 64'(ack8), 64'd0);
        check($sformatf("cd_e%0d_drop", e), 64'(drop8), 64'd1);
      end
    end
    check("cd_active", 64'(active8), 64'b0111);
    check("cd_x0", 64'(slot(pos_x8, 0)), 64'd64);

    // Asynchronous reset mid-flight
    fire_req = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    check("async_active", 64'(active8), 64'd0);
    check("async_pos", 64'({pos_x8, pos_y8}), 64'd0);
    check("async_pulses", 64'({ack8, drop8}), 64'd0);
    #1;
    Reset = 1'b0;
    fire_req = 1'b1; fire_dir = 2'b10; origin_x = 10'd7; origin_y = 10'd8;
    step();
    fire_req = 1'b0;
    check("post_rst_active", 64'(active8), 64'b0001);
    check("post_rst_xy", 64'({slot(pos_x8, 0), slot(pos_y8, 0)}), 64'({10'd7, 10'd8}));
    check("post_rst_ack", 64'(ack8), 64'd1);
    step();
    check("post_rst_down_y", 64'(slot(pos_y8, 0)), 64'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
